// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/commit sequencer and its helpers.
package cpu_pkg;

   // Sequencer states; encodings are fixed so other blocks can decode them.
   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      EXEC   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;  // sll $0,$0,0
   localparam logic [31:0] PC_STEP  = 32'd4;

   // Word-aligned byte offset from a 16-bit branch immediate.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage

// File: rtl/adder.sv
// 32-bit modulo-2^32 adder primitive.
module adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/mux_32.sv
// 32-bit 2:1 multiplexer primitive.
module mux_32 (
   input  logic [31:0] in0,
   input  logic [31:0] in1,
   input  logic        sel,
   output logic [31:0] y
);

   assign y = sel ? in1 : in0;

endmodule

// File: rtl/pc_next_calc.sv
// Combinational next-PC: sequential pc+4, or pc+4 plus the scaled branch offset.
module pc_next_calc
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [15:0] imm16,
   input  logic        nPC_sel,
   output logic [31:0] next_pc
);

   logic [31:0] pc_plus4;
   logic [31:0] pc_branch;

   adder u_add_seq (
      .a   (pc),
      .b   (PC_STEP),
      .sum (pc_plus4)
   );

   adder u_add_br (
      .a   (pc_plus4),
      .b   (branch_offset(imm16)),
      .sum (pc_branch)
   );

   mux_32 u_sel (
      .in0 (pc_plus4),
      .in1 (pc_branch),
      .sel (nPC_sel),
      .y   (next_pc)
   );

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/settle/commit sequencer feeding a single-cycle datapath.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] PC_RESET    = 32'h0000_0000,
   parameter int unsigned EXEC_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        nPC_sel,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        reg_wr_en,
   output logic        mem_wr_en,
   output logic        retire
);

   localparam logic [31:0] PcInit  = {PC_RESET[31:2], 2'b00};
   localparam logic [3:0]  CntLoad = 4'(EXEC_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        run_q;     // low until the first edge after reset release
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] next_pc;
   logic        latch_inst;
   logic        pc_update;

   pc_next_calc u_pc_next (
      .pc      (pc_q),
      .imm16   (inst_q[15:0]),
      .nPC_sel (nPC_sel),
      .next_pc (next_pc)
   );

   // Next-state and strobes, all decoded from the current state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      latch_inst = 1'b0;
      pc_update  = 1'b0;
      imem_req   = 1'b0;
      reg_wr_en  = 1'b0;
      mem_wr_en  = 1'b0;
      retire     = 1'b0;
      case (state_q)
         FETCH: begin
            imem_req = run_q;
            if (run_q && imem_ready) begin
               latch_inst = 1'b1;
               cnt_d      = CntLoad;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            if (!stall) begin
               if (cnt_q == 4'd0) begin
                  state_d = COMMIT;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         COMMIT: begin
            reg_wr_en = 1'b1;
            mem_wr_en = 1'b1;
            retire    = 1'b1;
            pc_update = 1'b1;
            state_d   = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Control state: FSM, settle counter and post-reset start flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         cnt_q   <= 4'd0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= 1'b1;
      end
   end

   // Architectural state: PC and the held instruction word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= PcInit;
         inst_q <= NOP_INST;
      end else begin
         if (latch_inst) inst_q <= imem_rdata;
         if (pc_update)  pc_q   <= next_pc;
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign inst      = inst_q;

endmodule
